// File: rtl/jump_target_unit.sv
// jump_target_unit: registered J/JAL/JR/BR target and link generator behind a valid/ready output stage.
// Define JUMP_TARGET_RAS_EN to add a circular return-address stack that flags JR targets matching its top.
module jump_target_unit #(
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 26,
  parameter int ALIGN     = 2,
  parameter int IMM_W     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [IDX_W-1:0]  in_idx,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic              in_taken,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_redirect,
  output logic [ADDR_W-1:0] out_target,
  output logic [ADDR_W-1:0] out_link,
  output logic              out_link_we,
  output logic              out_misalign,
  output logic              out_ras_hit
);
  if (IDX_W + ALIGN > ADDR_W) begin : g_bad_idx
    $error("IDX_W + ALIGN exceeds ADDR_W");
  end
  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
    $error("RAS_DEPTH must be a power of 2 and >= 2");
  end
  localparam logic [1:0] K_J = 2'b00, K_JAL = 2'b01, K_JR = 2'b10, K_BR = 2'b11;
  logic              fire, is_jr, is_jal, mis, redir_n, ras_hit_n;
  logic [ADDR_W-1:0] jmask, jtgt, boff, tgt_n, link_n;
  assign in_ready = (!out_valid || out_ready) && !flush;
  assign fire     = in_valid && in_ready;
  assign is_jr    = in_kind == K_JR;
  assign is_jal   = in_kind == K_JAL;
  // Masks rather than part-selects keep IDX_W+ALIGN==ADDR_W and ALIGN==0 legal.
  assign jmask  = {ADDR_W{1'b1}} << (IDX_W + ALIGN);
  assign jtgt   = (in_pc & jmask) | (ADDR_W'(in_idx) << ALIGN);
  assign boff   = ADDR_W'($signed(in_imm)) << ALIGN;
  assign mis    = is_jr && ((in_rs & ~({ADDR_W{1'b1}} << ALIGN)) != '0);
  assign link_n = in_pc + ADDR_W'(4);
  always_comb begin
    tgt_n   = is_jr ? in_rs : (in_kind == K_BR) ? (in_taken ? in_pc + boff : in_pc) : jtgt;
    redir_n = is_jr ? !mis : (in_kind == K_BR) ? in_taken : 1'b1;
  end
`ifdef JUMP_TARGET_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  logic [PW-1:0]     ptr;
  logic [PW:0]       cnt;
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [ADDR_W-1:0] top;
  assign top       = ras[ptr - 1'b1];
  assign ras_hit_n = is_jr && cnt != '0 && in_rs == top;
  // Pushing when full lands on the oldest slot, so the ring overwrites it naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (fire && is_jal) begin
      ptr <= ptr + 1'b1;
      cnt <= (cnt == (PW + 1)'(RAS_DEPTH)) ? cnt : cnt + 1'b1;
    end else if (fire && is_jr && cnt != '0) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (fire && is_jal) ras[ptr] <= link_n;
  end
`else
  assign ras_hit_n = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_redirect <= 1'b0;
      out_target   <= '0;
      out_link     <= '0;
      out_link_we  <= 1'b0;
      out_misalign <= 1'b0;
      out_ras_hit  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_redirect <= redir_n;
      out_target   <= tgt_n;
      out_link     <= link_n;
      out_link_we  <= is_jal;
      out_misalign <= mis;
      out_ras_hit  <= ras_hit_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
